// File: rtl/axi_lite_rd_arbiter.sv
// N-master to 1-slave AXI-lite read-channel arbiter with one transaction in flight.
// The grant is either fixed priority (lowest index wins) or round-robin.
module axi_lite_rd_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 64,
    parameter int DATA_W      = 64,
    parameter int ARB_MODE    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_arvalid,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_araddr,
    output logic [NUM_MASTERS-1:0]        m_arready,
    output logic [NUM_MASTERS-1:0]        m_rvalid,
    input  logic [NUM_MASTERS-1:0]        m_rready,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [1:0]                    m_rresp,
    output logic                          s_arvalid,
    output logic [ADDR_W-1:0]             s_araddr,
    input  logic                          s_arready,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    input  logic [DATA_W-1:0]             s_rdata,
    input  logic [1:0]                    s_rresp,
    output logic                          busy
);
    localparam int GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          state_reg;
    logic [GW-1:0]   grant_reg;
    logic [GW-1:0]   rr_ptr_reg;
    logic [GW-1:0]   grant_inc;
    logic            sel_found;
    logic [GW-1:0]   sel_idx;
    logic [GW-1:0]   cand_idx;
    logic [ADDR_W-1:0] addr_arr [NUM_MASTERS];

    generate
        for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            assign addr_arr[gi]  = m_araddr[gi*ADDR_W +: ADDR_W];
            assign m_arready[gi] = (state_reg == ADDR) && (grant_reg == GW'(gi)) && s_arready;
            assign m_rvalid[gi]  = (state_reg == DATA) && (grant_reg == GW'(gi)) && s_rvalid;
        end
    endgenerate

    // Search starts at rr_ptr in round-robin mode, at index 0 in fixed-priority mode.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (ARB_MODE != 0) begin
                cand_idx = GW'((int'(rr_ptr_reg) + k) % NUM_MASTERS);
            end else begin
                cand_idx = GW'(k);
            end
            if (!sel_found && m_arvalid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    assign grant_inc = (grant_reg == GW'(NUM_MASTERS - 1)) ? '0 : grant_reg + 1'b1;

    assign s_arvalid = (state_reg == ADDR);
    assign s_araddr  = (state_reg == ADDR) ? addr_arr[grant_reg] : '0;
    assign s_rready  = (state_reg == DATA) && m_rready[grant_reg];
    assign m_rdata   = (state_reg == DATA) ? s_rdata : '0;
    assign m_rresp   = (state_reg == DATA) ? s_rresp : 2'b00;
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (sel_found) begin
                        grant_reg <= sel_idx;
                        state_reg <= ADDR;
                    end
                end
                ADDR: begin
                    if (s_arready) begin
                        state_reg <= DATA;
                    end
                end
                DATA: begin
                    if (s_rvalid && s_rready) begin
                        state_reg <= IDLE;
                        if (ARB_MODE != 0) begin
                            rr_ptr_reg <= grant_inc;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/axi_lite_rd_arbiter.md
Name: axi_lite_rd_arbiter

Overview:
- Parametrised N-master to 1-slave AXI-lite read-channel arbiter for the pipeline's shared memory port.
- IFU instruction fetch and LSU loads, plus future DMA/debug masters, share one `ram_axi_lite` read port.
- One outstanding transaction in flight; grant is selectable between fixed-priority and round-robin.
- Sits between the pipeline stages and the RAM/CLINT read port; write channels bypass it.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_W, 64, AXI read address width
DATA_W, 64, AXI read data width
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
m_arvalid  input  NUM_MASTERS  per-master read address valid
m_araddr  input  NUM_MASTERS*ADDR_W  per-master address; master i occupies bits [i*ADDR_W +: ADDR_W]
m_arready  output  NUM_MASTERS  per-master address accepted
m_rvalid  output  NUM_MASTERS  per-master read data valid
m_rready  input  NUM_MASTERS  per-master read data ready
m_rdata  output  DATA_W  read data, broadcast to all masters
m_rresp  output  2  read response, broadcast to all masters
s_arvalid  output  1  slave address valid
s_araddr  output  ADDR_W  slave address
s_arready  input  1  slave address ready
s_rvalid  input  1  slave data valid
s_rready  output  1  slave data ready
s_rdata  input  DATA_W  slave read data
s_rresp  input  2  slave read response
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset: rst is sampled on the rising edge of clk; it is synchronous and active-high.
- Reset state: state = IDLE, grant = 0, rr_ptr = 0.
  - All outputs are 0: m_arready, m_rvalid, s_arvalid, s_rready, busy.
  - m_rdata and m_rresp are 0 because they are gated by state.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Selection is combinational over m_arvalid.
  - ARB_MODE=0: the lowest set index wins.
  - ARB_MODE=1: the first set index at or after rr_ptr wins, searching modulo NUM_MASTERS.
  - If any request is present, the winner is registered into grant and the FSM moves to ADDR on the next edge.
  - No outputs are asserted in IDLE.
- ADDR:
  - s_arvalid = 1 and s_araddr = m_araddr[grant].
  - m_arready[grant] = s_arready; all other m_arready bits are 0.
  - On s_arvalid && s_arready, the FSM moves to DATA.
  - Masters must hold arvalid and araddr until they see m_arready (AXI rule). The arbiter does not re-arbitrate while in ADDR.
- DATA:
  - m_rvalid[grant] = s_rvalid; all other m_rvalid bits are 0.
  - s_rready = m_rready[grant].
  - m_rdata = s_rdata and m_rresp = s_rresp while state == DATA, otherwise 0.
  - On the s_rvalid && s_rready handshake, the FSM returns to IDLE.
  - In ARB_MODE=1, rr_ptr becomes (grant+1) mod NUM_MASTERS on the same edge.
- Latency: a request in IDLE at cycle t produces s_arvalid at t+1.
  - With s_arready=1 at t+1, DATA is entered at t+2.
  - The minimum turnaround back to IDLE is 3 cycles per transaction.
- Simultaneous requests:
  - Exactly one grant per IDLE cycle.
  - Losers keep arvalid high and are considered again on the next IDLE cycle.
- Starvation: in ARB_MODE=1, a continuously requesting master is granted within NUM_MASTERS transactions.
- Non-grantee requests arriving in ADDR or DATA are ignored until IDLE.
- Error responses (s_rresp of 2'b10 or 2'b11) are passed through unchanged. The arbiter does not retry.
- Reset during ADDR or DATA:
  - The FSM aborts to IDLE on that edge and all outputs drop.
  - The slave shares rst and is reset in the same cycle, so no stray response is expected.
- A grant index beyond NUM_MASTERS-1 is unreachable. Width: grant and rr_ptr are $clog2(NUM_MASTERS) bits, minimum 1.

Test Plan:
1. NUM_MASTERS=2, ARB_MODE=1, reset held 2 cycles -> all outputs 0 and busy=0. Then m_arvalid=2'b01 with addr 0x8000_0000 -> s_arvalid at cycle +1 with s_araddr=0x8000_0000. Slave returns rdata 0x0000_0013_0000_0097 -> m_rvalid=2'b01 with the same data, and busy drops after the rready handshake.
2. Both masters request continuously, round-robin, 4 transactions -> grant order 0,1,0,1 with rr_ptr alternating; no double grant.
3. Same stimulus with ARB_MODE=0 -> grant order 0,0,0,0; master 1 is granted only after master 0 deasserts.
4. NUM_MASTERS=3, round-robin, rr_ptr=2, requests 3'b011 -> master 0 wins, then master 1. Slave holds s_arready=0 for 3 cycles -> s_arvalid stays high, m_arready stays 0, and s_araddr is stable.
5. Slave returns s_rresp=2'b10 and master holds m_rready=0 for 2 cycles -> m_rresp=2'b10 is held, FSM stays in DATA until rready, then returns to IDLE.
6. Assert rst in DATA with s_rvalid=0 -> next cycle state=IDLE, s_rready=0, busy=0. A fresh request afterwards completes normally in 3 cycles.
